// File: rtl/output_hold_pkg.sv
// Shared types and defaults for the output_hold block.
package output_hold_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } hold_state_t;

    localparam int DEFAULT_TICKS = 4;

endpackage

// File: rtl/hold_tick_gen.sv
// Shared prescaler: one-clock Tick every N clocks, first Tick on the N-th edge after reset.
module hold_tick_gen #(
    parameter int N = 2
) (
    input  logic Clock,
    input  logic Reset,
    output logic Tick
);

    generate
        if (N <= 1) begin : g_const
            // Every clock is a tick; clock and reset are not needed here.
            logic unused_in;
            assign unused_in = Clock ^ Reset;
            assign Tick      = 1'b1;
        end else begin : g_cnt
            localparam int CW = $clog2(N);
            logic [CW-1:0] cnt;

            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    cnt <= '0;
                end else if (cnt == CW'(N - 1)) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign Tick = (cnt == CW'(N - 1));
        end
    endgenerate

endmodule

// File: rtl/output_hold.sv
// Per-channel minimum-hold shaper for actuator outputs.
// Define OUTPUT_HOLD_SYNC_EN to insert a 2-flop input synchronizer (I->O latency 3).
module output_hold
    import output_hold_pkg::*;
#(
    parameter int Size          = 4,
    parameter int ClockPeriod_ns = 20,
    parameter int HoldPeriod_ns = 500_000,
    parameter int Ticks         = DEFAULT_TICKS
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [Size-1:0] I,
    output logic [Size-1:0] O,
    output logic [Size-1:0] Busy
);

    localparam int Prescale = HoldPeriod_ns / ClockPeriod_ns / Ticks;
    localparam int CW       = $clog2(Ticks + 1);

    logic            tick;
    logic [Size-1:0] level;

    hold_tick_gen #(
        .N(Prescale)
    ) u_tick (
        .Clock(Clock),
        .Reset(Reset),
        .Tick (tick)
    );

`ifdef OUTPUT_HOLD_SYNC_EN
    logic [Size-1:0] sync_q1;
    logic [Size-1:0] sync_q2;

    // Reset to ones so a released reset does not look like a requested change.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= I;
            sync_q2 <= sync_q1;
        end
    end

    assign level = sync_q2;
`else
    assign level = I;
`endif

    generate
        for (genvar c = 0; c < Size; c++) begin : g_ch
            hold_state_t   state;
            hold_state_t   state_nxt;
            logic [CW-1:0] cnt;
            logic [CW-1:0] cnt_nxt;
            logic          o_q;
            logic          o_nxt;

            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    state <= IDLE;
                    cnt   <= '0;
                    o_q   <= 1'b1;
                end else begin
                    state <= state_nxt;
                    cnt   <= cnt_nxt;
                    o_q   <= o_nxt;
                end
            end

            // A tick on the load edge is ignored: the IDLE branch never looks at it.
            always_comb begin
                state_nxt = state;
                cnt_nxt   = cnt;
                o_nxt     = o_q;
                case (state)
                    IDLE: begin
                        if (level[c] != o_q) begin
                            o_nxt     = level[c];
                            cnt_nxt   = CW'(Ticks);
                            state_nxt = HOLD;
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            cnt_nxt = cnt - 1'b1;
                            if (cnt == CW'(1)) begin
                                state_nxt = IDLE;
                            end
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end

            assign O[c]    = o_q;
            assign Busy[c] = (state == HOLD);
        end
    endgenerate

endmodule

// File: tb/tb_output_hold.sv
// Scoreboard bench for output_hold: driver pushes model predictions, monitor compares each edge.
module tb_output_hold;

    localparam int SIZE  = 4;
    localparam int CLK   = 20;
    localparam int HOLD  = 240;
    localparam int TICKS = 4;
    localparam int P     = HOLD / CLK / TICKS;

    typedef struct {
        logic [SIZE-1:0] o;
        logic [SIZE-1:0] busy;
        int              edge_n;
    } exp_t;

    logic            Clock = 1'b0;
    logic            Reset = 1'b1;
    logic [SIZE-1:0] I     = '1;
    logic [SIZE-1:0] O;
    logic [SIZE-1:0] Busy;

    int vectors    = 0;
    int miscompares = 0;

    exp_t exp_q[$];
    exp_t mon_e;

    // Model: edge count since reset release; per channel the load edge and the hold end edge.
    int              n;
    logic [SIZE-1:0] m_o;
    int              m_load[SIZE];
    int              m_end[SIZE];
    bit              m_hv[SIZE];
    logic [SIZE-1:0] m_s1, m_s2;

    output_hold #(
        .Size          (SIZE),
        .ClockPeriod_ns(CLK),
        .HoldPeriod_ns (HOLD),
        .Ticks         (TICKS)
    ) u_dut (
        .Clock(Clock),
        .Reset(Reset),
        .I    (I),
        .O    (O),
        .Busy (Busy)
    );

    always #(CLK / 2) Clock = ~Clock;

    task automatic model_reset();
        n    = 0;
        m_o  = '1;
        m_s1 = '1;
        m_s2 = '1;
        for (int c = 0; c < SIZE; c++) begin
            m_hv[c]   = 0;
            m_load[c] = 0;
            m_end[c]  = 0;
        end
    endtask

    function automatic bit in_hold(int c, int k);
        return m_hv[c] && (k >= m_load[c]) && (k < m_end[c]);
    endfunction

    // Drive one edge's input, predict the post-edge outputs, return just after the monitor sampled.
    task automatic step(input logic [SIZE-1:0] in);
        logic [SIZE-1:0] din;
        exp_t            e;
        @(negedge Clock);
        I = in;
        n++;
`ifdef OUTPUT_HOLD_SYNC_EN
        din  = m_s2;
        m_s2 = m_s1;
        m_s1 = in;
`else
        din = in;
`endif
        for (int c = 0; c < SIZE; c++) begin
            if (!in_hold(c, n - 1) && din[c] != m_o[c]) begin
                m_o[c]    = din[c];
                m_load[c] = n;
                // Hold ends on the TICKS-th tick strictly after the load edge; ticks land on multiples of P.
                m_end[c]  = (n / P + 1) * P + (TICKS - 1) * P;
                m_hv[c]   = 1;
            end
        end
        e.o      = m_o;
        for (int c = 0; c < SIZE; c++) e.busy[c] = in_hold(c, n);
        e.edge_n = n;
        exp_q.push_back(e);
        @(posedge Clock);
        #2;
    endtask

    task automatic check(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    always @(posedge Clock) begin
        if (!Reset) begin
            #1;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_empty: got output with no prediction at t=%0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("O edge %0d", mon_e.edge_n), O, mon_e.o);
                check($sformatf("Busy edge %0d", mon_e.edge_n), Busy, mon_e.busy);
            end
        end
    end

    initial begin
        int len;
        logic [SIZE-1:0] v;
        model_reset();
        repeat (2) @(posedge Clock);
        #2;
        check("reset O", O, '1);
        check("reset Busy", Busy, '0);
        Reset = 1'b0;

        // Quiet idle, then channel 0 falls; measure its hold length directly too.
        repeat (4) step(4'b1111);
        step(4'b1110);
        len = 1;
        for (int k = 0; k < 30 && Busy[0]; k++) begin
            step(4'b1110);
            if (Busy[0]) len++;
        end
        vectors++;
        if (len < (TICKS - 1) * P + 1 || len > TICKS * P) begin
            miscompares++;
            $display("FAIL hold_len ch0: got %0d cycles expected %0d..%0d", len, (TICKS - 1) * P + 1, TICKS * P);
        end
        repeat (3) step(4'b1110);

        // Single-cycle pulse on channel 1 is stretched to the full window.
        step(4'b1100);
        repeat (16) step(4'b1110);

        // Channel 2 toggling every cycle.
        v = 4'b1110;
        for (int k = 0; k < 40; k++) begin
            v[2] = ~v[2];
            step(v);
        end
        repeat (14) step(4'b1111);

        // Reset in the middle of a channel 3 hold.
        step(4'b0111);
        repeat (2) step(4'b0111);
        Reset = 1'b1;
        #1;
        check("async reset O", O, '1);
        check("async reset Busy", Busy, '0);
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        model_reset();
        step(4'b0111);
        repeat (14) step(4'b0111);

        // Random traffic, biased toward short-lived changes.
        v = 4'b1111;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) v = 4'($urandom);
            step(v);
        end

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/output_hold.md
OUTPUT_HOLD -- requirements
Module: output_hold

Interface
REQ-001 Parameter Size, default 4: number of independent channels.
REQ-002 Parameter ClockPeriod_ns, default 20: Clock period in ns.
REQ-003 Parameter HoldPeriod_ns, default 500_000: minimum time each output level is held, in ns.
REQ-004 Parameter Ticks, default 4: hold length in prescaler ticks.
REQ-005 Clock  input  1  system clock, all logic on rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 I  input  Size  requested output levels, one bit per channel.
REQ-008 O  output  Size  shaped output levels to actuator drivers.
REQ-009 Busy  output  Size  per-channel flag: channel is in its hold window.

Function
REQ-010 Prescale SHALL equal HoldPeriod_ns / ClockPeriod_ns / Ticks (integer division); if Prescale <= 1 the tick SHALL be constant 1.
REQ-011 Tick SHALL be a one-clock pulse when the prescale counter equals Prescale-1; the counter counts 0..Prescale-1 and wraps to 0.
REQ-012 One tick generator SHALL be shared by all channels.
REQ-013 Each channel SHALL run an independent two-state FSM: IDLE, HOLD.
REQ-014 IDLE with I[i] != O[i]: O[i] SHALL take I[i] at the next edge (1-cycle latency), FSM -> HOLD, hold counter loaded with Ticks.
REQ-015 IDLE with I[i] == O[i]: no change.
REQ-016 HOLD: O[i] SHALL NOT change regardless of I[i]; each tick decrements the hold counter.
REQ-017 A tick coinciding with the IDLE->HOLD load edge SHALL NOT be counted.
REQ-018 When a tick decrements the counter from 1 to 0, FSM SHALL return to IDLE on that edge.
REQ-019 On the first IDLE cycle after HOLD, if I[i] != O[i], REQ-014 applies immediately (pending level taken from current I, not from history).
REQ-020 Busy[i] SHALL be 1 exactly while FSM[i] is HOLD.
REQ-021 Hold counter width SHALL be $clog2(Ticks+1); Ticks >= 1.
REQ-022 Resulting hold duration SHALL lie in [(Ticks-1)*Prescale+1, Ticks*Prescale] clocks.
REQ-023 Pulses on I shorter than the hold window SHALL be stretched to the full hold window, not suppressed.

Reset
REQ-024 While Reset is 1: O = all ones, Busy = all zeros, all FSMs IDLE, hold counters 0, prescale counter 0.
REQ-025 Reset asserted mid-HOLD SHALL abort the hold immediately (asynchronously); no pending level is kept.
REQ-026 After Reset release, first tick SHALL occur on the Prescale-th rising edge.

Configuration
REQ-027 Macro OUTPUT_HOLD_SYNC_EN defined: I SHALL pass through a 2-flop synchronizer (reset to all ones) before the FSMs; latency I->O becomes 3 cycles.
REQ-028 Macro undefined: I feeds the FSMs directly, latency 1 cycle.

Structure
REQ-029 Package output_hold_pkg SHALL hold the state typedef (IDLE, HOLD) and the default Ticks constant.
REQ-030 Sub-module hold_tick_gen (parameter N, ports Clock, Reset, Tick) SHALL implement REQ-010/011/026.
REQ-031 FSM, hold counter and output register per channel SHALL be built with a generate loop over Size.

Verification (Size=4, ClockPeriod_ns=20, HoldPeriod_ns=240, Ticks=4 -> Prescale=3; macro undefined unless stated)
REQ-032 Reset release, I=4'b1111 -> O=4'b1111, Busy=4'b0000; first Tick on 3rd edge.
REQ-033 I[0] 1->0 at cycle t -> O[0]=0 at t+1, Busy[0]=1 for 10..12 cycles, then 0; other channels unchanged.
REQ-034 I[1] single-cycle 0 pulse -> O[1]=0 for full hold window, then back to 1 one cycle after Busy[1] falls.
REQ-035 I[2] toggles every cycle for 40 cycles -> O[2] changes only in first IDLE cycle after each hold; no O[2] level shorter than 10 cycles.
REQ-036 Reset pulsed mid-HOLD on channel 3 with I[3]=0 -> O[3]=1, Busy[3]=0 immediately; after release O[3]=0 one cycle later.
REQ-037 OUTPUT_HOLD_SYNC_EN defined, I[0] 1->0 at t -> O[0]=0 at t+3.
